// File: rtl/ov5640_pkg.sv
// rtl/ov5640_pkg.sv - shared types and default delays for the OV5640 power-down sequencer
package ov5640_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    RST_LOW,
    PWDN_HI,
    DONE
  } pd_state_t;

  // Default delays in sys_clk cycles at 100 MHz
  localparam int DLY_1MS   = 100000;
  localparam int DLY_2MS   = 200000;
  localparam int DLY_100MS = 10000000;

  // Wide enough for DLY_100MS-1
  localparam int CNT_W_DEF = 24;

endpackage

// File: rtl/ov5640_sync_fall.sv
// rtl/ov5640_sync_fall.sv - two-flop synchronizer with registered falling-edge pulse
module ov5640_sync_fall (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic async_in,
  output logic fall_pulse
);

  logic sync_meta;
  logic sync_q;
  logic sync_d;

  // Resynchronize the input and flag a 1->0 transition of the synchronized level
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      sync_d     <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_meta  <= async_in;
      sync_q     <= sync_meta;
      sync_d     <= sync_q;
      fall_pulse <= sync_d & ~sync_q;
    end
  end

endmodule

// File: rtl/ov5640_power_down.sv
// rtl/ov5640_power_down.sv - frame-aligned RESETB/PWDN shutdown sequencer for the OV5640
module ov5640_power_down
  import ov5640_pkg::*;
#(
  parameter int T_FRAME_TO  = DLY_100MS,
  parameter int T_RST_PWDN  = DLY_1MS,
  parameter int T_PWDN_HOLD = DLY_2MS,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic pd_start,
  input  logic cam_vsync,
  output logic pd_active,
  output logic pd_busy,
  output logic pd_done,
  output logic pd_timeout,
  output logic ov5640_rstb,
  output logic ov5640_pwdn
);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(T_FRAME_TO - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(T_RST_PWDN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_PWDN_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  pd_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             vs_fall;

  ov5640_sync_fall u_vsync_fall (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .async_in   (cam_vsync),
    .fall_pulse (vs_fall)
  );

  // Sequencer: every pin change is registered on the same edge as its state change
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pd_active   <= 1'b0;
      pd_busy     <= 1'b0;
      pd_done     <= 1'b0;
      pd_timeout  <= 1'b0;
      ov5640_rstb <= 1'b1;
      ov5640_pwdn <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pd_start) begin
            state     <= WAIT_FRAME;
            pd_busy   <= 1'b1;
            pd_active <= 1'b1;
          end
        end

        WAIT_FRAME: begin
          // A VSYNC edge on the terminal count still counts as a clean frame end
          if (vs_fall) begin
            state       <= RST_LOW;
            cnt         <= '0;
            ov5640_rstb <= 1'b0;
          end else if (cnt == FRAME_LAST) begin
            state       <= RST_LOW;
            cnt         <= '0;
            ov5640_rstb <= 1'b0;
            pd_timeout  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        RST_LOW: begin
          if (cnt == RST_LAST) begin
            state       <= PWDN_HI;
            cnt         <= '0;
            ov5640_pwdn <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PWDN_HI: begin
          if (cnt == HOLD_LAST) begin
            state   <= DONE;
            cnt     <= '0;
            pd_done <= 1'b1;
            pd_busy <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DONE: begin
          cnt         <= '0;
          pd_active   <= 1'b1;
          pd_busy     <= 1'b0;
          pd_done     <= 1'b1;
          ov5640_rstb <= 1'b0;
          ov5640_pwdn <= 1'b1;
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
